// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, default datapath width and the memory-stage FSM state type.
package cpu_pkg;

  localparam int DW_DEFAULT = 16;

  localparam logic [3:0] OP_LOAD  = 4'b1010;
  localparam logic [3:0] OP_STORE = 4'b1011;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  // Every opcode other than STORE and NOP writes its result to the register bank.
  function automatic logic op_writes_reg(input logic [3:0] op);
    return (op != OP_STORE) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port data memory: synchronous write, registered read, DEPTH x DW, contents never reset.
module data_ram
  import cpu_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU pass-through, STORE/LOAD to data_ram, one-beat writeback register with backpressure.
// Optional operand-bypass outputs fwd_* are built when MEM_STAGE_FWD_EN is defined.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op,
  input  logic [2:0]    rd,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] store_data,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic          wb_we,
  output logic [2:0]    wb_rd,
  output logic [DW-1:0] wb_data
`ifdef MEM_STAGE_FWD_EN
  ,
  output logic          fwd_valid,
  output logic [2:0]    fwd_rd,
  output logic [DW-1:0] fwd_data
`endif
);

  localparam int AW = $clog2(DEPTH);

  state_t        state_q;
  logic          wb_valid_q;
  logic          wb_we_q;
  logic [2:0]    wb_rd_q;
  logic [DW-1:0] wb_data_q;
  logic [2:0]    ld_rd_q;
  logic [DW-1:0] rd_word;
  logic          accept;
  logic          ram_we;
  logic          ram_re;

  assign in_ready = (state_q == IDLE) && (!wb_valid_q || wb_ready);
  // Gate with rst so nothing presented during reset reaches the memory.
  assign accept   = in_valid && in_ready && !rst;
  assign ram_we   = accept && (op == OP_STORE);
  assign ram_re   = accept && (op == OP_LOAD);

  data_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (alu_result[AW-1:0]),
    .wdata_i (store_data),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk) begin
    if (ram_re) ld_rd_q <= rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 3'd0;
      wb_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op == OP_LOAD) begin
              // Any previous beat is being consumed this edge; the load beat follows next cycle.
              state_q    <= LOAD_WAIT;
              wb_valid_q <= 1'b0;
            end else begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= op_writes_reg(op);
              wb_rd_q    <= rd;
              wb_data_q  <= alu_result;
            end
          end else if (wb_ready) begin
            wb_valid_q <= 1'b0;
          end
        end
        LOAD_WAIT: begin
          state_q    <= IDLE;
          wb_valid_q <= 1'b1;
          wb_we_q    <= 1'b1;
          wb_rd_q    <= ld_rd_q;
          wb_data_q  <= rd_word;
        end
      endcase
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

`ifdef MEM_STAGE_FWD_EN
  assign fwd_valid = wb_valid_q && wb_we_q;
  assign fwd_rd    = wb_rd_q;
  assign fwd_data  = wb_data_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; fwd_* checks are compiled in with MEM_STAGE_FWD_EN.
module tb_mem_stage;

  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [2:0]    rd;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] store_data;
  logic          wb_valid;
  logic          wb_ready;
  logic          wb_we;
  logic [2:0]    wb_rd;
  logic [DW-1:0] wb_data;
`ifdef MEM_STAGE_FWD_EN
  logic          fwd_valid;
  logic [2:0]    fwd_rd;
  logic [DW-1:0] fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  mem_stage #(.DW(DW), .DEPTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .rd         (rd),
    .alu_result (alu_result),
    .store_data (store_data),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
`ifdef MEM_STAGE_FWD_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] o, input logic [2:0] r,
                         input logic [DW-1:0] a, input logic [DW-1:0] s);
    in_valid = 1'b1; op = o; rd = r; alu_result = a; store_data = s;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b1;
    op = 4'd0; rd = 3'd0; alu_result = '0; store_data = '0;
    #3;
    cyc(); cyc();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %0b want 0", wb_valid); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rst_wb_we: got %0b want 0", wb_we); end
    checks++; if (wb_rd !== 3'd0) begin errors++; $display("FAIL rst_wb_rd: got %0d want 0", wb_rd); end
    checks++; if (wb_data !== 16'h0000) begin errors++; $display("FAIL rst_wb_data: got %h want 0000", wb_data); end
    rst = 1'b0;
    cyc();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %0b want 0", wb_valid); end
  endtask

  task automatic test_alu();
    present(4'b0000, 3'd3, 16'h0042, 16'h0000);
    cyc();
    in_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %0b want 1", wb_valid); end
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL alu_we: got %0b want 1", wb_we); end
    checks++; if (wb_rd !== 3'd3) begin errors++; $display("FAIL alu_rd: got %0d want 3", wb_rd); end
    checks++; if (wb_data !== 16'h0042) begin errors++; $display("FAIL alu_data: got %h want 0042", wb_data); end
`ifdef MEM_STAGE_FWD_EN
    checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 3'd3 || fwd_data !== 16'h0042) begin
      errors++; $display("FAIL alu_fwd: got v=%0b rd=%0d d=%h want v=1 rd=3 d=0042", fwd_valid, fwd_rd, fwd_data); end
`endif
    cyc();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_drain: got %0b want 0", wb_valid); end
  endtask

  task automatic test_store_load_wrap();
    present(4'b1011, 3'd1, 16'h0005, 16'hBEEF);
    cyc();
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin
      errors++; $display("FAIL st_beat: got v=%0b we=%0b want v=1 we=0", wb_valid, wb_we); end
    present(4'b1010, 3'd6, 16'h0025, 16'h0000);
    cyc();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_wait_ready: got %0b want 0", in_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ld_wait_valid: got %0b want 0", wb_valid); end
    cyc();
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b1) begin
      errors++; $display("FAIL ld_beat: got v=%0b we=%0b want v=1 we=1", wb_valid, wb_we); end
    checks++; if (wb_rd !== 3'd6) begin errors++; $display("FAIL ld_rd: got %0d want 6", wb_rd); end
    checks++; if (wb_data !== 16'hBEEF) begin errors++; $display("FAIL ld_wrap_data: got %h want beef", wb_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ld_after_ready: got %0b want 1", in_ready); end
    cyc();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ld_drain: got %0b want 0", wb_valid); end
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    present(4'b0000, 3'd2, 16'h1234, 16'h0000);
    cyc();
    present(4'b0001, 3'd5, 16'h5678, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, in_ready); end
      checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 3'd2 || wb_data !== 16'h1234) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%0b we=%0b rd=%0d d=%h want v=1 we=1 rd=2 d=1234",
                           i, wb_valid, wb_we, wb_rd, wb_data); end
      cyc();
    end
    wb_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 3'd5 || wb_data !== 16'h5678) begin
      errors++; $display("FAIL bp_next: got v=%0b rd=%0d d=%h want v=1 rd=5 d=5678", wb_valid, wb_rd, wb_data); end
    cyc();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", wb_valid); end
  endtask

  task automatic test_reset_load();
    present(4'b1011, 3'd0, 16'h0009, 16'hA5A5);
    cyc();
    present(4'b1010, 3'd4, 16'h0009, 16'h0000);
    cyc();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rl_wait: got %0b want 0", in_ready); end
    rst = 1'b1;
    #2;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rl_async: got %0b want 0", wb_valid); end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rl_no_beat[%0d]: got %0b want 0", i, wb_valid); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rl_idle: got %0b want 1", in_ready); end
    // STORE presented while reset is high must not commit
    rst = 1'b1;
    present(4'b1011, 3'd0, 16'h0009, 16'h2222);
    cyc();
    in_valid = 1'b0;
    rst = 1'b0;
    cyc();
    present(4'b1010, 3'd4, 16'h0009, 16'h0000);
    cyc();
    in_valid = 1'b0;
    cyc();
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 3'd4 || wb_data !== 16'hA5A5) begin
      errors++; $display("FAIL rl_mem_kept: got v=%0b rd=%0d d=%h want v=1 rd=4 d=a5a5", wb_valid, wb_rd, wb_data); end
    cyc();
  endtask

  task automatic test_nop_store();
    present(4'b1111, 3'd7, 16'h0011, 16'h0000);
    cyc();
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin
      errors++; $display("FAIL nop_beat: got v=%0b we=%0b want v=1 we=0", wb_valid, wb_we); end
`ifdef MEM_STAGE_FWD_EN
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL nop_fwd: got %0b want 0", fwd_valid); end
`endif
    present(4'b1011, 3'd2, 16'h0003, 16'h0077);
    cyc();
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin
      errors++; $display("FAIL st2_beat: got v=%0b we=%0b want v=1 we=0", wb_valid, wb_we); end
`ifdef MEM_STAGE_FWD_EN
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL st2_fwd: got %0b want 0", fwd_valid); end
`endif
    present(4'b1010, 3'd1, 16'h0023, 16'h0000);
    cyc();
    in_valid = 1'b0;
    cyc();
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 3'd1 || wb_data !== 16'h0077) begin
      errors++; $display("FAIL st2_load: got v=%0b rd=%0d d=%h want v=1 rd=1 d=0077", wb_valid, wb_rd, wb_data); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_load_wrap();
    test_backpressure();
    test_reset_load();
    test_nop_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
